// File: rtl/led_matrix_pkg.sv
// -----------------------------------------------------------------------------
// led_matrix_pkg
// Shared definitions for the row-multiplexed LED matrix scanner:
//   - scan_state_e : scanner FSM states (IDLE / BLANK / SHOW)
//   - CH_GREEN/RED : colour channel indices used on wr_ch
//   - safe_clog2   : clog2 that never returns less than 1, so that index
//                    ports keep a legal width even for single-entry axes
// -----------------------------------------------------------------------------
package led_matrix_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_e;

  localparam int CH_GREEN = 0;
  localparam int CH_RED   = 1;

  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_fb_ram.sv
// -----------------------------------------------------------------------------
// led_fb_ram
// Framebuffer: ROWS words of CHANNELS*COLS bits. Bit (ch*COLS + x) of word y
// holds pixel (x, y) of channel ch.
// Ports:
//   clk, reset     : clock, synchronous active-high reset (clears all words)
//   clear_i        : one-cycle pulse, zeroes every word; beats a same-cycle write
//   wr_en_i        : single-bit write strobe; out-of-range coordinates ignored
//   wr_x_i/wr_y_i/wr_ch_i/wr_val_i : pixel address and value
//   rd_row_i       : combinational row-read address
//   rd_data_o      : contents of word rd_row_i (pre-edge value, so a write in
//                    the same cycle is not visible until the next cycle)
// -----------------------------------------------------------------------------
module led_fb_ram
  import led_matrix_pkg::*;
#(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int CHANNELS = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clear_i,
  input  logic                             wr_en_i,
  input  logic [safe_clog2(COLS)-1:0]      wr_x_i,
  input  logic [safe_clog2(ROWS)-1:0]      wr_y_i,
  input  logic [safe_clog2(CHANNELS)-1:0]  wr_ch_i,
  input  logic                             wr_val_i,
  input  logic [safe_clog2(ROWS)-1:0]      rd_row_i,
  output logic [CHANNELS*COLS-1:0]         rd_data_o
);

  localparam int W  = CHANNELS * COLS;
  localparam int BW = safe_clog2(W);

  // Whole-array clear in one cycle rules out a RAM macro; this stays in flops.
  logic [W-1:0]  mem_q [ROWS];
  logic          wr_ok;
  logic [BW-1:0] bit_idx;

  assign wr_ok = wr_en_i
              && (int'(wr_x_i)  < COLS)
              && (int'(wr_y_i)  < ROWS)
              && (int'(wr_ch_i) < CHANNELS);

  assign bit_idx = BW'(int'(wr_ch_i) * COLS + int'(wr_x_i));

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      for (int r = 0; r < ROWS; r++) begin
        mem_q[r] <= '0;
      end
    end else if (wr_ok) begin
      mem_q[wr_y_i][bit_idx] <= wr_val_i;
    end
  end

  assign rd_data_o = (int'(rd_row_i) < ROWS) ? mem_q[rd_row_i] : '0;

endmodule

// File: rtl/led_matrix_scanner.sv
// -----------------------------------------------------------------------------
// led_matrix_scanner
// Row-multiplexed LED matrix driver with internal framebuffer. Rows are lit one
// at a time for DWELL_CYCLES, separated by BLANK_CYCLES with every line off.
// Columns show a snapshot of the row taken on the last blanking cycle.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   enable           : 1 = scanning, 0 = dark (IDLE, row_idx back to 0)
//   clear            : one-cycle pulse, zeroes the framebuffer
//   wr_en/wr_x/wr_y/wr_ch/wr_val : pixel write port
//   row_out          : anode lines, only row_idx at ROW_ACTIVE during SHOW
//   col_out          : cathode lines, channel c at [c*COLS +: COLS]
//   row_idx          : row currently lit or about to be lit
//   frame_tick       : one-cycle pulse when the scan wraps to row 0
// -----------------------------------------------------------------------------
module led_matrix_scanner
  import led_matrix_pkg::*;
#(
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int CHANNELS     = 2,
  parameter int DWELL_CYCLES = 6250,
  parameter int BLANK_CYCLES = 50,
  parameter bit ROW_ACTIVE   = 1'b1,
  parameter bit COL_ACTIVE   = 1'b0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic                             clear,
  input  logic                             wr_en,
  input  logic [safe_clog2(COLS)-1:0]      wr_x,
  input  logic [safe_clog2(ROWS)-1:0]      wr_y,
  input  logic [safe_clog2(CHANNELS)-1:0]  wr_ch,
  input  logic                             wr_val,
  output logic [ROWS-1:0]                  row_out,
  output logic [CHANNELS*COLS-1:0]         col_out,
  output logic [safe_clog2(ROWS)-1:0]      row_idx,
  output logic                             frame_tick
);

  localparam int YW      = safe_clog2(ROWS);
  localparam int W       = CHANNELS * COLS;
  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = safe_clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [YW-1:0]    ROW_LAST   = YW'(ROWS - 1);

  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [YW-1:0]    row_idx_q, row_idx_d;
  logic [W-1:0]     snap_q, snap_d;
  logic [ROWS-1:0]  row_out_q, row_out_d;
  logic [W-1:0]     col_out_q, col_out_d;
  logic             frame_tick_q, frame_tick_d;
  logic             show_d;
  logic [W-1:0]     fb_row;

  led_fb_ram #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .CHANNELS (CHANNELS)
  ) u_fb (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (clear),
    .wr_en_i   (wr_en),
    .wr_x_i    (wr_x),
    .wr_y_i    (wr_y),
    .wr_ch_i   (wr_ch),
    .wr_val_i  (wr_val),
    .rd_row_i  (row_idx_q),
    .rd_data_o (fb_row)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      row_idx_q    <= '0;
      snap_q       <= '0;
      row_out_q    <= {ROWS{~ROW_ACTIVE}};
      col_out_q    <= {W{~COL_ACTIVE}};
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      row_idx_q    <= row_idx_d;
      snap_q       <= snap_d;
      row_out_q    <= row_out_d;
      col_out_q    <= col_out_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_idx_d = row_idx_q;
    if (!enable) begin
      state_d   = IDLE;
      cnt_d     = '0;
      row_idx_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = BLANK;
          cnt_d     = '0;
          row_idx_d = '0;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        SHOW: begin
          if (cnt_q == DWELL_LAST) begin
            state_d   = BLANK;
            cnt_d     = '0;
            row_idx_d = (row_idx_q == ROW_LAST) ? '0 : row_idx_q + YW'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d   = IDLE;
          cnt_d     = '0;
          row_idx_d = '0;
        end
      endcase
    end
  end

  // Output logic. Outputs are computed from the next state so the registered
  // lines line up exactly with state_q.
  always_comb begin
    show_d = (state_d == SHOW);
    // Snapshot on the last blanking cycle; fb_row is the pre-edge word, so a
    // write landing on this same edge is not captured.
    snap_d = (enable && state_q == BLANK && cnt_q == BLANK_LAST) ? fb_row : snap_q;
    frame_tick_d = enable && (state_q == SHOW) && (cnt_q == DWELL_LAST)
                && (row_idx_q == ROW_LAST);
    row_out_d = {ROWS{~ROW_ACTIVE}};
    col_out_d = {W{~COL_ACTIVE}};
    for (int r = 0; r < ROWS; r++) begin
      if (show_d && (row_idx_d == YW'(r))) row_out_d[r] = ROW_ACTIVE;
    end
    for (int b = 0; b < W; b++) begin
      if (show_d && snap_d[b]) col_out_d[b] = COL_ACTIVE;
    end
  end

  assign row_out    = row_out_q;
  assign col_out    = col_out_q;
  assign row_idx    = row_idx_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// -----------------------------------------------------------------------------
// tb_led_matrix_scanner
// Directed bench for led_matrix_scanner. Main instance: 8x8, 2 channels,
// dwell 4, blank 2 (row period 6, frame period 48). A second small instance
// (3x3, 2 channels) reaches coordinates outside the matrix, which the 8x8
// ports cannot encode. Inputs change and outputs are sampled on negedge.
// -----------------------------------------------------------------------------
module tb_led_matrix_scanner;
  import led_matrix_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, enable, clear, wr_en, wr_val;
  logic [2:0]  wr_x, wr_y;
  logic [0:0]  wr_ch;
  logic [7:0]  row_out;
  logic [15:0] col_out;
  logic [2:0]  row_idx;
  logic        frame_tick;

  logic        s_enable, s_wr_en, s_wr_val;
  logic [1:0]  s_wr_x, s_wr_y;
  logic [0:0]  s_wr_ch;
  logic [2:0]  s_row_out;
  logic [5:0]  s_col_out;
  logic [1:0]  s_row_idx;
  logic        s_frame_tick;

  int checks   = 0;
  int failures = 0;

  led_matrix_scanner #(
    .ROWS(8), .COLS(8), .CHANNELS(2), .DWELL_CYCLES(4), .BLANK_CYCLES(2),
    .ROW_ACTIVE(1'b1), .COL_ACTIVE(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_ch(wr_ch), .wr_val(wr_val),
    .row_out(row_out), .col_out(col_out), .row_idx(row_idx), .frame_tick(frame_tick)
  );

  led_matrix_scanner #(
    .ROWS(3), .COLS(3), .CHANNELS(2), .DWELL_CYCLES(2), .BLANK_CYCLES(1),
    .ROW_ACTIVE(1'b1), .COL_ACTIVE(1'b0)
  ) dut_small (
    .clk(clk), .reset(reset), .enable(s_enable), .clear(1'b0),
    .wr_en(s_wr_en), .wr_x(s_wr_x), .wr_y(s_wr_y), .wr_ch(s_wr_ch), .wr_val(s_wr_val),
    .row_out(s_row_out), .col_out(s_col_out), .row_idx(s_row_idx), .frame_tick(s_frame_tick)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic write_px(input int x, input int y, input int ch, input logic v);
    wr_en = 1'b1; wr_x = 3'(x); wr_y = 3'(y); wr_ch = 1'(ch); wr_val = v;
    step();
    wr_en = 1'b0;
  endtask

  task automatic s_write_px(input int x, input int y, input int ch, input logic v);
    s_wr_en = 1'b1; s_wr_x = 2'(x); s_wr_y = 2'(y); s_wr_ch = 1'(ch); s_wr_val = v;
    step();
    s_wr_en = 1'b0;
  endtask

  task automatic wait_row(input logic [7:0] pat, input string tag);
    int n = 0;
    while (row_out !== pat && n < 200) begin step(); n++; end
    if (row_out !== pat) check({tag, "_timeout"}, 32'(row_out), 32'(pat));
  endtask

  task automatic wait_leave(input logic [7:0] pat, input string tag);
    int n = 0;
    while (row_out === pat && n < 200) begin step(); n++; end
    if (row_out === pat) check({tag, "_stuck"}, 32'(row_out), 32'h0);
  endtask

  task automatic s_wait_row(input logic [2:0] pat, input string tag);
    int n = 0;
    while (s_row_out !== pat && n < 100) begin step(); n++; end
    if (s_row_out !== pat) check({tag, "_timeout"}, 32'(s_row_out), 32'(pat));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_row;
    int n;
    reset = 1'b1; enable = 1'b0; clear = 1'b0; wr_en = 1'b0; wr_val = 1'b0;
    wr_x = '0; wr_y = '0; wr_ch = '0;
    s_enable = 1'b0; s_wr_en = 1'b0; s_wr_val = 1'b0;
    s_wr_x = '0; s_wr_y = '0; s_wr_ch = '0;
    repeat (3) step();

    // Reset state
    check("rst_row_out", 32'(row_out), 32'h00);
    check("rst_col_out", 32'(col_out), 32'hFFFF);
    check("rst_row_idx", 32'(row_idx), 32'h0);
    check("rst_frame_tick", 32'(frame_tick), 32'h0);

    // 1: empty framebuffer, one full frame plus the wrap
    reset = 1'b0; enable = 1'b1; s_enable = 1'b1;
    step();
    for (int k = 0; k < 50; k++) begin
      exp_row = ((k % 6) < 2) ? 8'h00 : (8'h01 << ((k / 6) % 8));
      check("t1_row_out", 32'(row_out), 32'(exp_row));
      check("t1_col_out", 32'(col_out), 32'hFFFF);
      check("t1_row_idx", 32'(row_idx), 32'((k / 6) % 8));
      check("t1_frame_tick", 32'(frame_tick), (k == 48) ? 32'h1 : 32'h0);
      step();
    end

    // 2: two pixels on row 2, one per channel
    write_px(3, 2, CH_GREEN, 1'b1);
    write_px(7, 2, CH_RED, 1'b1);
    wait_row(8'h04, "t2_wait_row2");
    for (int i = 0; i < 4; i++) begin
      check("t2_row2_row_out", 32'(row_out), 32'h04);
      check("t2_row2_col_out", 32'(col_out), 32'h7FF7);
      step();
    end
    check("t2_blank_row_out", 32'(row_out), 32'h00);
    check("t2_blank_col_out", 32'(col_out), 32'hFFFF);
    check("t2_blank_row_idx", 32'(row_idx), 32'h3);
    wait_row(8'h08, "t2_wait_row3");
    check("t2_row3_col_out", 32'(col_out), 32'hFFFF);

    // 3: write into row 5 while it is lit; no change until next frame
    wait_row(8'h20, "t3_wait_row5");
    write_px(0, 5, CH_GREEN, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("t3_row5_same_frame_col", 32'(col_out), 32'hFFFF);
      step();
    end
    wait_row(8'h20, "t3_wait_row5_next");
    check("t3_row5_next_frame_col", 32'(col_out), 32'hFFFE);

    // 4: clear with a simultaneous write; clear wins
    clear = 1'b1; wr_en = 1'b1; wr_x = 3'd1; wr_y = 3'd1; wr_ch = 1'(CH_GREEN); wr_val = 1'b1;
    step();
    clear = 1'b0; wr_en = 1'b0;
    wait_row(8'h02, "t4_wait_row1");
    check("t4_row1_col", 32'(col_out), 32'hFFFF);
    wait_row(8'h04, "t4_wait_row2");
    check("t4_row2_col", 32'(col_out), 32'hFFFF);
    wait_row(8'h20, "t4_wait_row5");
    check("t4_row5_col", 32'(col_out), 32'hFFFF);

    // Write on the snapshot cycle of row 6: snapshot keeps the old value
    n = 0;
    while (!(row_idx === 3'd6 && row_out === 8'h00) && n < 200) begin step(); n++; end
    check("t4_row6_blank_idx", 32'(row_idx), 32'h6);
    step();
    write_px(4, 6, CH_RED, 1'b1);
    check("t4_row6_snap_row_out", 32'(row_out), 32'h40);
    check("t4_row6_snap_old_col", 32'(col_out), 32'hFFFF);
    wait_leave(8'h40, "t4_leave_row6");
    wait_row(8'h40, "t4_wait_row6_next");
    check("t4_row6_next_col", 32'(col_out), 32'hEFFF);

    // 6: pixel on row 3, then drop enable during row 3 SHOW
    write_px(2, 3, CH_GREEN, 1'b1);
    wait_row(8'h08, "t6_wait_row3");
    check("t6_row3_col", 32'(col_out), 32'hFFFB);
    step();
    enable = 1'b0;
    step();
    check("t6_off_row_out", 32'(row_out), 32'h00);
    check("t6_off_col_out", 32'(col_out), 32'hFFFF);
    check("t6_off_row_idx", 32'(row_idx), 32'h0);
    check("t6_off_frame_tick", 32'(frame_tick), 32'h0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("t6_idle_row_out", 32'(row_out), 32'h00);
      check("t6_idle_row_idx", 32'(row_idx), 32'h0);
    end
    enable = 1'b1;
    step();
    check("t6_re_blank0_row_out", 32'(row_out), 32'h00);
    check("t6_re_blank0_row_idx", 32'(row_idx), 32'h0);
    step();
    check("t6_re_blank1_row_out", 32'(row_out), 32'h00);
    step();
    check("t6_re_show_row_out", 32'(row_out), 32'h01);
    check("t6_re_show_col_out", 32'(col_out), 32'hFFFF);
    wait_row(8'h08, "t6_wait_row3_kept");
    check("t6_row3_kept_col", 32'(col_out), 32'hFFFB);

    // Reset in the middle of SHOW
    step();
    reset = 1'b1;
    step();
    check("t6_rst_row_out", 32'(row_out), 32'h00);
    check("t6_rst_col_out", 32'(col_out), 32'hFFFF);
    check("t6_rst_row_idx", 32'(row_idx), 32'h0);
    check("t6_rst_frame_tick", 32'(frame_tick), 32'h0);
    reset = 1'b0;
    wait_row(8'h08, "t6_wait_row3_after_rst");
    check("t6_row3_cleared_col", 32'(col_out), 32'hFFFF);

    // 5: out-of-range coordinates on the 3x3 instance
    s_write_px(3, 0, CH_GREEN, 1'b1);
    s_write_px(0, 3, CH_GREEN, 1'b1);
    s_write_px(2, 0, CH_RED, 1'b1);
    s_wait_row(3'b100, "t5_wait_row2");
    s_wait_row(3'b001, "t5_wait_row0");
    check("t5_row0_col", 32'(s_col_out), 32'h1F);
    check("t5_row0_idx", 32'(s_row_idx), 32'h0);
    s_wait_row(3'b010, "t5_wait_row1");
    check("t5_row1_col", 32'(s_col_out), 32'h3F);
    s_wait_row(3'b100, "t5_wait_row2b");
    check("t5_row2_col", 32'(s_col_out), 32'h3F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
